// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_pkg
//  Purpose  : Shared encodings for the pipeline hazard controller:
//             forward-select codes, mult/div op classes, Tuse sentinel
//             and a saturating Tnew decrement helper.
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // Forward-select encodings shared by D- and E-stage bypass muxes
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;
    localparam logic [1:0] FWD_E  = 2'd3;

    // Tuse value meaning "this source register is not read"
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Mult/div unit interaction class of a D-stage instruction
    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MULT = 2'b01,
        MD_DIV  = 2'b10,
        MD_HILO = 2'b11
    } md_op_e;

    // Result latency shrinks by one per stage advance, never below zero
    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_md_busy_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : md_busy_cnt
//  Purpose  : Mult/div busy counter. Loads the unit latency when a mult or
//             div enters E, then counts down to zero; busy while nonzero.
//  Revision : 1.0 - initial release
// ============================================================================
module md_busy_cnt #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load_mult,
    input  logic load_div,
    output logic busy
);

    localparam logic [CNT_W-1:0] c_mult_load = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_CYC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: a new op reloads, otherwise count down towards idle
    always_comb begin
        cnt_d = cnt_q;
        if (load_div) begin
            cnt_d = c_div_load;
        end else if (load_mult) begin
            cnt_d = c_mult_load;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, cleared by reset even mid-operation
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Central hazard controller for the 5-stage MIPS pipeline.
//             Tracks destination/Tnew of the E, M and W instructions, compares
//             them with D-stage sources and Tuse, and produces the D stall,
//             E bubble and D/E forward selects. Stalls HI/LO users while the
//             mult/div unit is busy.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] tuse_rs_D,
    input  logic [1:0] tuse_rt_D,
    input  logic [4:0] a3_D,
    input  logic [1:0] tnew_D,
    input  logic [1:0] md_op_D,
    output logic       stall,
    output logic       flush_E,
    output logic [1:0] fwd_rs_D,
    output logic [1:0] fwd_rt_D,
    output logic [1:0] fwd_rs_E,
    output logic [1:0] fwd_rt_E,
    output logic       md_busy
);

    // ------------------------------------------------------------------
    // Stage tracking state
    // ------------------------------------------------------------------
    logic [4:0] e_a3_q,   e_a3_d;
    logic [1:0] e_tnew_q, e_tnew_d;
    logic [4:0] e_rs_q,   e_rs_d;
    logic [4:0] e_rt_q,   e_rt_d;
    logic [4:0] m_a3_q,   m_a3_d;
    logic [1:0] m_tnew_q, m_tnew_d;
    logic [4:0] w_a3_q,   w_a3_d;

    logic w_data_stall;
    logic w_md_stall;
    logic w_load_mult;
    logic w_load_div;

    // Source s in D must wait if a producer in E or M cannot deliver in time
    function automatic logic src_stall(
        input logic [4:0] s,
        input logic [1:0] tuse,
        input logic [4:0] ea3,
        input logic [1:0] etnew,
        input logic [4:0] ma3,
        input logic [1:0] mtnew
    );
        if (tuse == TUSE_NONE || s == 5'd0) begin
            return 1'b0;
        end
        return ((ea3 == s) && (etnew > tuse)) || ((ma3 == s) && (mtnew > tuse));
    endfunction

    // Nearest producer wins; a not-yet-ready nearest producer masks older ones
    function automatic logic [1:0] d_fwd(
        input logic [4:0] s,
        input logic [4:0] ea3,
        input logic [1:0] etnew,
        input logic [4:0] ma3,
        input logic [1:0] mtnew,
        input logic [4:0] wa3
    );
        if (s == 5'd0) begin
            return FWD_RF;
        end
        if (ea3 == s) begin
            return (etnew == 2'd0) ? FWD_E : FWD_RF;
        end
        if (ma3 == s) begin
            return (mtnew == 2'd0) ? FWD_M : FWD_RF;
        end
        if (wa3 == s) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    // E-stage bypass: M has priority over W
    function automatic logic [1:0] e_fwd(
        input logic [4:0] s,
        input logic [4:0] ma3,
        input logic [1:0] mtnew,
        input logic [4:0] wa3
    );
        if (s == 5'd0) begin
            return FWD_RF;
        end
        if (ma3 == s) begin
            return (mtnew == 2'd0) ? FWD_M : FWD_RF;
        end
        if (wa3 == s) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    // Stall decision and forward selects, purely combinational
    always_comb begin
        w_data_stall = src_stall(rs_D, tuse_rs_D, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q)
                     | src_stall(rt_D, tuse_rt_D, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);
        w_md_stall   = (md_op_D != MD_NONE) && md_busy;
        stall        = w_data_stall | w_md_stall;
        flush_E      = stall;
        fwd_rs_D     = d_fwd(rs_D, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
        fwd_rt_D     = d_fwd(rt_D, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
        fwd_rs_E     = e_fwd(e_rs_q, m_a3_q, m_tnew_q, w_a3_q);
        fwd_rt_E     = e_fwd(e_rt_q, m_a3_q, m_tnew_q, w_a3_q);
        w_load_mult  = !stall && (md_op_D == MD_MULT);
        w_load_div   = !stall && (md_op_D == MD_DIV);
    end

    // Next stage contents: E takes D or a bubble, M and W simply shift
    always_comb begin
        e_a3_d   = 5'd0;
        e_tnew_d = 2'd0;
        e_rs_d   = 5'd0;
        e_rt_d   = 5'd0;
        if (!stall) begin
            e_a3_d   = a3_D;
            e_tnew_d = tnew_D;
            e_rs_d   = (tuse_rs_D == TUSE_NONE) ? 5'd0 : rs_D;
            e_rt_d   = (tuse_rt_D == TUSE_NONE) ? 5'd0 : rt_D;
        end
        m_a3_d   = e_a3_q;
        m_tnew_d = sat_dec(e_tnew_q);
        w_a3_d   = m_a3_q;
    end

    // Stage registers
    always_ff @(posedge clk) begin
        if (reset) begin
            e_a3_q   <= 5'd0;
            e_tnew_q <= 2'd0;
            e_rs_q   <= 5'd0;
            e_rt_q   <= 5'd0;
            m_a3_q   <= 5'd0;
            m_tnew_q <= 2'd0;
            w_a3_q   <= 5'd0;
        end else begin
            e_a3_q   <= e_a3_d;
            e_tnew_q <= e_tnew_d;
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            m_a3_q   <= m_a3_d;
            m_tnew_q <= m_tnew_d;
            w_a3_q   <= w_a3_d;
        end
    end

    md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_cnt (
        .clk       (clk),
        .reset     (reset),
        .load_mult (w_load_mult),
        .load_div  (w_load_div),
        .busy      (md_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Self-checking bench for hazard_ctrl: directed vector table,
//             multi-cycle mult/div and reset sequences, and random traffic
//             against an instruction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, a3_D;
    logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D, md_op_D;
    logic       stall, flush_E, md_busy;
    logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .rs_D      (rs_D),
        .rt_D      (rt_D),
        .tuse_rs_D (tuse_rs_D),
        .tuse_rt_D (tuse_rt_D),
        .a3_D      (a3_D),
        .tnew_D    (tnew_D),
        .md_op_D   (md_op_D),
        .stall     (stall),
        .flush_E   (flush_E),
        .fwd_rs_D  (fwd_rs_D),
        .fwd_rt_D  (fwd_rt_D),
        .fwd_rs_E  (fwd_rs_E),
        .fwd_rt_E  (fwd_rt_E),
        .md_busy   (md_busy)
    );

    int checks   = 0;
    int failures = 0;

    // ------------------------------------------------------------------
    // Reference model: the three in-flight instructions as issued, index
    // 0 = E, 1 = M, 2 = W. Remaining latency is derived from the age.
    // ------------------------------------------------------------------
    typedef struct {
        int a3;
        int tnew;
        int rs;
        int rt;
    } instr_t;

    instr_t pipe [3];
    int     cyc;
    int     md_start;
    int     md_len;

    // Packed view {stall, flush_E, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, md_busy}
    logic [10:0] got_v;
    logic [10:0] exp_v;

    function automatic int remaining(input int k);
        if (k == 2) return 0;
        return (pipe[k].tnew > k) ? pipe[k].tnew - k : 0;
    endfunction

    function automatic bit hit(input int k, input int s);
        return (s != 0) && (pipe[k].a3 == s);
    endfunction

    function automatic bit model_busy();
        return (cyc >= md_start) && (cyc < md_start + md_len);
    endfunction

    function automatic int model_fwd(input int s, input int first);
        for (int k = first; k < 3; k++) begin
            if (hit(k, s)) begin
                if (remaining(k) != 0) return 0;
                return (k == 0) ? 3 : ((k == 1) ? 1 : 2);
            end
        end
        return 0;
    endfunction

    function automatic bit model_src_stall(input int s, input int tuse);
        if (tuse == 3) return 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (hit(k, s) && remaining(k) > tuse) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
        md_start = -1000;
        md_len   = 0;
    endfunction

    function automatic logic [10:0] pack(input int s, input int a, input int b,
                                         input int c, input int d, input int bz);
        return {1'(s), 1'(s), 2'(a), 2'(b), 2'(c), 2'(d), 1'(bz)};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One pipeline cycle: drive D, sample outputs mid-cycle, advance model at the edge
    task automatic apply(input int r, input int rs, input int rt, input int tr,
                         input int tt, input int a3, input int tn, input int md);
        bit     s;
        instr_t nxt;
        reset     = 1'(r);
        rs_D      = 5'(rs);
        rt_D      = 5'(rt);
        tuse_rs_D = 2'(tr);
        tuse_rt_D = 2'(tt);
        a3_D      = 5'(a3);
        tnew_D    = 2'(tn);
        md_op_D   = 2'(md);
        @(negedge clk);
        got_v = {stall, flush_E, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, md_busy};
        s = model_src_stall(rs, tr) | model_src_stall(rt, tt) | ((md != 0) && model_busy());
        exp_v = pack(int'(s), model_fwd(rs, 0), model_fwd(rt, 0),
                     model_fwd(pipe[0].rs, 1), model_fwd(pipe[0].rt, 1), int'(model_busy()));
        if (r != 0) begin
            model_reset();
        end else begin
            if (!s && (md == 1 || md == 2)) begin
                md_start = cyc + 1;
                md_len   = (md == 1) ? 5 : 10;
            end
            nxt = s ? '{0, 0, 0, 0} : '{a3, tn, (tr == 3) ? 0 : rs, (tt == 3) ? 0 : rt};
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nxt;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        apply(0, 0, 0, 3, 3, 0, 0, 0);
    endtask

    typedef struct {
        int          rs, rt, tr, tt, a3, tn, md;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(input int rs, input int rt, input int tr, input int tt,
                                input int a3, input int tn, input int md, input logic [10:0] e);
        vec_t v;
        v = '{rs, rt, tr, tt, a3, tn, md, e};
        tbl.push_back(v);
    endfunction

    initial begin
        int n;
        cyc = 0;
        model_reset();
        reset = 1'b1;
        rs_D = '0; rt_D = '0; a3_D = '0;
        tuse_rs_D = '0; tuse_rt_D = '0; tnew_D = '0; md_op_D = '0;
        @(posedge clk);
        #1;
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0);

        // Reset state with all-zero D inputs
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_state", int'(got_v), 0);

        // Directed table: ALU bypass, load-use, $0, Tnew==0 bypass from E
        add(1, 2, 1, 1, 3, 1, 0, pack(0, 0, 0, 0, 0, 0));  // addu $3
        add(3, 0, 1, 3, 6, 1, 0, pack(0, 0, 0, 0, 0, 0));  // uses $3, no stall
        add(3, 0, 1, 3, 7, 1, 0, pack(0, 1, 0, 1, 0, 0));  // $3 from M (D and E)
        add(0, 0, 3, 3, 0, 0, 0, pack(0, 0, 0, 2, 0, 0));  // E consumer takes W
        add(1, 0, 1, 3, 5, 2, 0, pack(0, 0, 0, 0, 0, 0));  // lw $5
        add(5, 0, 0, 3, 0, 0, 0, pack(1, 0, 0, 0, 0, 0));  // beq $5 stall 1
        add(5, 0, 0, 3, 0, 0, 0, pack(1, 0, 0, 0, 0, 0));  // beq $5 stall 2
        add(5, 0, 0, 3, 0, 0, 0, pack(0, 2, 0, 0, 0, 0));  // beq $5 from W
        add(1, 0, 1, 3, 5, 2, 0, pack(0, 0, 0, 0, 0, 0));  // lw $5
        add(0, 5, 3, 1, 8, 1, 0, pack(1, 0, 0, 0, 0, 0));  // addu rt=$5 stall
        add(0, 5, 3, 1, 8, 1, 0, pack(0, 0, 0, 0, 0, 0));  // released
        add(0, 0, 3, 3, 0, 0, 0, pack(0, 0, 0, 0, 2, 0));  // rt from W in E
        add(0, 0, 0, 0, 0, 2, 0, pack(0, 0, 0, 0, 0, 0));  // write to $0
        add(0, 0, 0, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0));  // $0 source, E/M hold $0
        add(0, 0, 0, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0));
        add(0, 0, 3, 3, 9, 0, 0, pack(0, 0, 0, 0, 0, 0));  // producer with Tnew 0
        add(9, 9, 0, 2, 0, 0, 0, pack(0, 3, 3, 0, 0, 0));  // both from E
        add(0, 0, 3, 3, 0, 0, 0, pack(0, 0, 0, 1, 1, 0));  // both from M in E
        foreach (tbl[i]) begin
            apply(0, tbl[i].rs, tbl[i].rt, tbl[i].tr, tbl[i].tt, tbl[i].a3, tbl[i].tn, tbl[i].md);
            check($sformatf("vec%0d", i), int'(got_v), int'(tbl[i].exp));
        end

        // div keeps the unit busy for exactly DIV_CYC cycles
        apply(0, 0, 0, 3, 3, 0, 0, 2);
        check("div_entry_not_busy", int'(got_v[0]), 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            nop();
            if (got_v[0]) n++;
            else break;
        end
        check("div_busy_cycles", n, 10);

        // HI/LO access behind a div stalls for the full latency
        apply(0, 0, 0, 3, 3, 0, 0, 2);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            apply(0, 0, 0, 3, 3, 0, 0, 3);
            if (got_v[10]) n++;
            else break;
        end
        check("div_mfhi_stall", n, 10);

        // Same for mult
        apply(0, 0, 0, 3, 3, 0, 0, 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            apply(0, 0, 0, 3, 3, 0, 0, 3);
            if (got_v[10]) n++;
            else break;
        end
        check("mult_mfhi_stall", n, 5);

        // Reset in the middle of a div with lw $4 in E
        apply(0, 0, 0, 3, 3, 0, 0, 2);
        nop();
        nop();
        apply(0, 1, 0, 1, 3, 4, 2, 0);
        apply(1, 4, 0, 0, 3, 0, 0, 0);
        check("pre_reset_busy_stall", int'({got_v[10], got_v[0]}), 3);
        apply(0, 4, 0, 0, 3, 0, 0, 0);
        check("post_reset_clear", int'(got_v), 0);

        // Random traffic over a small register set against the model
        for (int i = 0; i < 600; i++) begin
            int r, md, sel;
            r   = ($urandom_range(0, 63) == 0) ? 1 : 0;
            sel = $urandom_range(0, 11);
            md  = (sel == 0) ? 1 : (sel == 1) ? 2 : (sel == 2) ? 3 : 0;
            apply(r, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), md);
            check($sformatf("rand%0d", i), int'(got_v), int'(exp_v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
